// File: rtl/sdram_sched_pkg.sv
// Shared encodings, field widths and default thresholds for the SDRAM frame scheduler.
// Also holds the row-to-address packing helper used by both request sides.
package sdram_sched_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    localparam int ADDR_W        = 24;
    localparam int ROW_W         = 13;
    localparam int FIFO_W        = 11;
    localparam int TMO_W         = 12;
    localparam int SCHED_ROW_LSB = 9;
    localparam int BANK_W        = ADDR_W - ROW_W - SCHED_ROW_LSB;

    localparam int ROWS_DEF        = 128;
    localparam int WR_THRESH_DEF   = 512;
    localparam int RD_THRESH_DEF   = 512;
    localparam int WR_URGENT_DEF   = 1536;
    localparam int ACK_TIMEOUT_DEF = 4095;

    // Bank bits above the row field and column bits below it are always zero.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] row, input int lsb);
        return ADDR_W'(row) << lsb;
    endfunction

endpackage

// File: rtl/sched_row_ctr.sv
// 13-bit row counter with clear, increment and saturate-at-limit controls.
// Clear wins over increment; increment is ignored once the count reaches sat_i.
module sched_row_ctr
    import sdram_sched_pkg::*;
(
    input  logic             clk_133M,
    input  logic             rst_133,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [ROW_W-1:0] sat_i,
    output logic [ROW_W-1:0] cnt_o
);

    logic [ROW_W-1:0] cnt_q, cnt_d;

    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < sat_i)) begin
            cnt_d = cnt_q + ROW_W'(1);
        end
    end

    // NOTE: non-blocking assignments for every flop so all registers update together.
    always_ff @(posedge clk_133M or negedge rst_133) begin
        if (!rst_133) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sdram_frame_sched.sv
// Write-then-read row burst scheduler for the single-port SDRAM request interface.
// Optional ack watchdog enabled by defining SDRAM_SCHED_ACK_TIMEOUT_EN.
module sdram_frame_sched
    import sdram_sched_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int ROW_LSB   = SCHED_ROW_LSB,
    parameter int WR_THRESH = WR_THRESH_DEF,
    parameter int RD_THRESH = RD_THRESH_DEF,
`ifdef SDRAM_SCHED_ACK_TIMEOUT_EN
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
`endif
    parameter int WR_URGENT = WR_URGENT_DEF
) (
    input  logic              clk_133M,
    input  logic              rst_133,
    input  logic              vsync_i,
    input  logic [FIFO_W-1:0] wr_fifo_used_i,
    input  logic [FIFO_W-1:0] rd_fifo_used_i,
    input  logic              wr_sdram_ack_i,
    input  logic              rd_sdram_ack_i,
    output logic              wr_sdram_req_o,
    output logic [ADDR_W-1:0] wr_sdram_add_o,
    output logic              rd_sdram_req_o,
    output logic [ADDR_W-1:0] rd_sdram_add_o,
    output logic              wr_done_o,
    output logic [7:0]        frame_rows_o,
    output logic              err_o
);

    logic             vs_meta_q, vs_s_q;
    logic [1:0]       state_q, state_d;
    logic             wr_done_q, wr_done_d;
    logic [ROW_W-1:0] wr_row, rd_row;
    logic             wr_ack_ok, rd_ack_ok, tmo_hit;
    logic             wr_elig, rd_elig, wr_urgent;
    logic             rd_inc, rd_clr;

    // VSYNC crosses in from the pixel clock domain.
    always_ff @(posedge clk_133M or negedge rst_133) begin
        if (!rst_133) begin
            vs_meta_q <= 1'b0;
            vs_s_q    <= 1'b0;
        end else begin
            vs_meta_q <= vsync_i;
            vs_s_q    <= vs_meta_q;
        end
    end

    assign wr_ack_ok = (state_q == ST_WR_WAIT) && wr_sdram_ack_i;
    assign rd_ack_ok = (state_q == ST_RD_WAIT) && rd_sdram_ack_i;

    assign wr_elig   = !wr_done_q && (wr_fifo_used_i >= FIFO_W'(WR_THRESH));
    assign wr_urgent = wr_fifo_used_i >= FIFO_W'(WR_URGENT);
    assign rd_elig   = wr_done_q && vs_s_q && (rd_fifo_used_i <= FIFO_W'(RD_THRESH))
                       && (rd_row < ROW_W'(ROWS));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_elig && (!rd_elig || wr_urgent)) begin
                    state_d = ST_WR_WAIT;
                end else if (rd_elig) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: if (wr_ack_ok || tmo_hit) state_d = ST_IDLE;
            ST_RD_WAIT: if (rd_ack_ok || tmo_hit) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // A read finishing inside the blank restarts the frame instead of advancing it.
    assign rd_inc    = rd_ack_ok && vs_s_q;
    assign rd_clr    = !vs_s_q && ((state_q == ST_IDLE) || rd_ack_ok);
    assign wr_done_d = wr_done_q || (wr_ack_ok && (wr_row == ROW_W'(ROWS - 1)));

    always_ff @(posedge clk_133M or negedge rst_133) begin
        if (!rst_133) begin
            state_q   <= ST_IDLE;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_done_q <= wr_done_d;
        end
    end

    sched_row_ctr u_wr_row (
        .clk_133M (clk_133M),
        .rst_133  (rst_133),
        .inc_i    (wr_ack_ok),
        .clr_i    (1'b0),
        .sat_i    (ROW_W'(ROWS)),
        .cnt_o    (wr_row)
    );

    sched_row_ctr u_rd_row (
        .clk_133M (clk_133M),
        .rst_133  (rst_133),
        .inc_i    (rd_inc),
        .clr_i    (rd_clr),
        .sat_i    (ROW_W'(ROWS)),
        .cnt_o    (rd_row)
    );

`ifdef SDRAM_SCHED_ACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q;
    logic             in_wait;

    assign in_wait = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);
    assign tmo_hit = in_wait && !wr_ack_ok && !rd_ack_ok && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (in_wait && !wr_ack_ok && !rd_ack_ok && !tmo_hit) tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk_133M or negedge rst_133) begin
        if (!rst_133) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_q || tmo_hit;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign wr_sdram_req_o = (state_q == ST_WR_WAIT);
    assign rd_sdram_req_o = (state_q == ST_RD_WAIT);
    assign wr_sdram_add_o = row_addr(wr_row, ROW_LSB);
    assign rd_sdram_add_o = row_addr(rd_row, ROW_LSB);
    assign wr_done_o      = wr_done_q;
    assign frame_rows_o   = rd_row[7:0];

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched: idle-grant vector tables plus hand-written
// write-fill, read-frame, blanking, saturation and reset sequences.
module tb_sdram_frame_sched;

    typedef struct {
        int wr_used;
        int rd_used;
        bit vs;
        bit exp_wr;
        bit exp_rd;
    } vec_t;

    logic        clk_133M = 1'b0;
    logic        rst_133;
    logic        vsync_i;
    logic [10:0] wr_fifo_used_i;
    logic [10:0] rd_fifo_used_i;
    logic        wr_sdram_ack_i;
    logic        rd_sdram_ack_i;
    logic        wr_sdram_req_o;
    logic [23:0] wr_sdram_add_o;
    logic        rd_sdram_req_o;
    logic [23:0] rd_sdram_add_o;
    logic        wr_done_o;
    logic [7:0]  frame_rows_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int model_wr = 0;
    int model_rd = 0;
    int wr_rise = 0;
    bit wr_prev = 1'b0;
    bit both_hi = 1'b0;

    vec_t pre_v[5];
    vec_t post_v[5];

    always #4 clk_133M = ~clk_133M;

    sdram_frame_sched dut (
        .clk_133M       (clk_133M),
        .rst_133        (rst_133),
        .vsync_i        (vsync_i),
        .wr_fifo_used_i (wr_fifo_used_i),
        .rd_fifo_used_i (rd_fifo_used_i),
        .wr_sdram_ack_i (wr_sdram_ack_i),
        .rd_sdram_ack_i (rd_sdram_ack_i),
        .wr_sdram_req_o (wr_sdram_req_o),
        .wr_sdram_add_o (wr_sdram_add_o),
        .rd_sdram_req_o (rd_sdram_req_o),
        .rd_sdram_add_o (rd_sdram_add_o),
        .wr_done_o      (wr_done_o),
        .frame_rows_o   (frame_rows_o),
        .err_o          (err_o)
    );

    always @(negedge clk_133M) begin
        if (wr_sdram_req_o && !wr_prev) wr_rise++;
        wr_prev = wr_sdram_req_o;
        if (wr_sdram_req_o && rd_sdram_req_o) both_hi = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_133M);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic quiesce();
        wr_fifo_used_i = 11'd0;
        rd_fifo_used_i = 11'd2047;
    endtask

    task automatic wait_req(input bit is_wr, input int budget, output int n);
        n = 0;
        while (((is_wr ? wr_sdram_req_o : rd_sdram_req_o) == 1'b0) && (n < budget)) begin
            tick();
            n++;
        end
        check(is_wr ? "wr_req_seen" : "rd_req_seen", is_wr ? wr_sdram_req_o : rd_sdram_req_o, 1);
    endtask

    // Wait for the request, check its row address, ack after 5 cycles, check the drop.
    task automatic burst(input bit is_wr, input int exp_row);
        int n;
        wait_req(is_wr, 200, n);
        check(is_wr ? "wr_add" : "rd_add", is_wr ? wr_sdram_add_o : rd_sdram_add_o,
              32'(exp_row) << 9);
        repeat (4) tick();
        check(is_wr ? "wr_req_held" : "rd_req_held", is_wr ? wr_sdram_req_o : rd_sdram_req_o, 1);
        if (is_wr) wr_sdram_ack_i = 1'b1;
        else       rd_sdram_ack_i = 1'b1;
        tick();
        wr_sdram_ack_i = 1'b0;
        rd_sdram_ack_i = 1'b0;
        check(is_wr ? "wr_req_drop" : "rd_req_drop", is_wr ? wr_sdram_req_o : rd_sdram_req_o, 0);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        wr_fifo_used_i = 11'(v.wr_used);
        rd_fifo_used_i = 11'(v.rd_used);
        vsync_i        = v.vs;
        repeat (4) tick();
        check({tag, "_wr_req"}, wr_sdram_req_o, v.exp_wr);
        check({tag, "_rd_req"}, rd_sdram_req_o, v.exp_rd);
        if (v.exp_wr) begin
            check({tag, "_wr_add"}, wr_sdram_add_o, 32'(model_wr) << 9);
            wr_sdram_ack_i = 1'b1;
            tick();
            wr_sdram_ack_i = 1'b0;
            check({tag, "_wr_drop"}, wr_sdram_req_o, 0);
            model_wr++;
        end else if (v.exp_rd) begin
            check({tag, "_rd_add"}, rd_sdram_add_o, 32'(model_rd) << 9);
            rd_sdram_ack_i = 1'b1;
            tick();
            rd_sdram_ack_i = 1'b0;
            check({tag, "_rd_drop"}, rd_sdram_req_o, 0);
            model_rd++;
            check({tag, "_rows"}, frame_rows_o, model_rd);
        end else if (!v.vs) begin
            model_rd = 0;
            check({tag, "_rows_blank"}, frame_rows_o, 0);
        end
        quiesce();
    endtask

    initial begin
        int n;

        // Before the frame is stored only writes compete, so these all resolve to writes or idle.
        pre_v[0] = '{511, 100, 1'b1, 1'b0, 1'b0};
        pre_v[1] = '{0, 0, 1'b1, 1'b0, 1'b0};
        pre_v[2] = '{512, 100, 1'b1, 1'b1, 1'b0};
        pre_v[3] = '{600, 0, 1'b1, 1'b1, 1'b0};
        pre_v[4] = '{1600, 0, 1'b0, 1'b1, 1'b0};
        // After wr_done only reads can be granted, whatever the write FIFO level.
        post_v[0] = '{0, 513, 1'b1, 1'b0, 1'b0};
        post_v[1] = '{0, 512, 1'b1, 1'b0, 1'b1};
        post_v[2] = '{2047, 100, 1'b1, 1'b0, 1'b1};
        post_v[3] = '{2047, 2047, 1'b0, 1'b0, 1'b0};
        post_v[4] = '{1600, 100, 1'b1, 1'b0, 1'b1};

        rst_133        = 1'b0;
        vsync_i        = 1'b0;
        wr_sdram_ack_i = 1'b0;
        rd_sdram_ack_i = 1'b0;
        quiesce();
        #2;
        check("rst_wr_req", wr_sdram_req_o, 0);
        check("rst_rd_req", rd_sdram_req_o, 0);
        check("rst_wr_add", wr_sdram_add_o, 0);
        check("rst_rd_add", rd_sdram_add_o, 0);
        check("rst_wr_done", wr_done_o, 0);
        check("rst_rows", frame_rows_o, 0);
        check("rst_err", err_o, 0);
        repeat (3) tick();
        rst_133 = 1'b1;
        tick();

        // Acks while idle must not move either row counter.
        wr_sdram_ack_i = 1'b1;
        rd_sdram_ack_i = 1'b1;
        tick();
        wr_sdram_ack_i = 1'b0;
        rd_sdram_ack_i = 1'b0;
        check("idle_ack_wr_add", wr_sdram_add_o, 0);

        for (int i = 0; i < 5; i++) apply_vec($sformatf("pre%0d", i), pre_v[i]);

        // Row 3: a read ack during a write burst is ignored.
        wr_fifo_used_i = 11'd512;
        wait_req(1'b1, 20, n);
        tick();
        rd_sdram_ack_i = 1'b1;
        tick();
        rd_sdram_ack_i = 1'b0;
        check("rdack_in_wr_req", wr_sdram_req_o, 1);
        check("rdack_in_wr_add", wr_sdram_add_o, 32'(3) << 9);
        wr_sdram_ack_i = 1'b1;
        tick();
        wr_sdram_ack_i = 1'b0;
        check("row3_drop", wr_sdram_req_o, 0);

        for (int r = 4; r < 128; r++) begin
            if (r == 127) check("wr_done_before_last", wr_done_o, 0);
            burst(1'b1, r);
        end
        check("wr_done_set", wr_done_o, 1);
        repeat (20) tick();
        check("no_129th_req", wr_sdram_req_o, 0);
        check("wr_req_count", wr_rise, 128);

        // Read frame, rows 0..39 back to back.
        wr_fifo_used_i = 11'd1600;
        rd_fifo_used_i = 11'd100;
        vsync_i        = 1'b1;
        for (int r = 0; r < 40; r++) begin
            burst(1'b0, r);
            check("rd_rows", frame_rows_o, r + 1);
            tick();
            check("rd_rereq_2cyc", rd_sdram_req_o, 1);
        end

        // Blank starts while row 40 is outstanding.
        check("rd40_add", rd_sdram_add_o, 32'(40) << 9);
        vsync_i = 1'b0;
        repeat (5) tick();
        check("rd40_held_in_blank", rd_sdram_req_o, 1);
        rd_sdram_ack_i = 1'b1;
        tick();
        rd_sdram_ack_i = 1'b0;
        check("rd40_drop", rd_sdram_req_o, 0);
        check("rd40_add_cleared", rd_sdram_add_o, 0);
        check("rd40_rows_cleared", frame_rows_o, 0);
        repeat (10) tick();
        check("no_rd_in_blank", rd_sdram_req_o, 0);
        vsync_i = 1'b1;
        wait_req(1'b0, 20, n);
        check("vsync_sync_latency", n, 3);
        check("rd_restart_add", rd_sdram_add_o, 0);

        // Full frame to saturation, then the blank clears the count.
        for (int r = 0; r < 128; r++) burst(1'b0, r);
        check("rd_rows_full", frame_rows_o, 128);
        repeat (10) tick();
        check("rd_saturated_no_req", rd_sdram_req_o, 0);
        check("rd_sat_add", rd_sdram_add_o, 32'(128) << 9);
        vsync_i = 1'b0;
        quiesce();
        repeat (3) tick();
        check("blank_clears_rows", frame_rows_o, 0);

        model_rd = 0;
        for (int i = 0; i < 5; i++) apply_vec($sformatf("post%0d", i), post_v[i]);

`ifdef SDRAM_SCHED_ACK_TIMEOUT_EN
        rd_fifo_used_i = 11'd100;
        wait_req(1'b0, 20, n);
        check("tmo_add", rd_sdram_add_o, 32'(model_rd) << 9);
        n = 0;
        while (rd_sdram_req_o && (n < 5000)) begin
            tick();
            n++;
        end
        check("tmo_len", n, 4095);
        check("tmo_err", err_o, 1);
        wait_req(1'b0, 20, n);
        check("tmo_retry_add", rd_sdram_add_o, 32'(model_rd) << 9);
        rd_sdram_ack_i = 1'b1;
        tick();
        rd_sdram_ack_i = 1'b0;
        quiesce();
        tick();
        check("tmo_err_sticky", err_o, 1);
`else
        check("err_tied0", err_o, 0);
`endif

        check("req_exclusive", both_hi, 0);

        // Asynchronous reset in the middle of a write burst.
        rst_133 = 1'b0;
        tick();
        rst_133 = 1'b1;
        wr_fifo_used_i = 11'd512;
        burst(1'b1, 0);
        burst(1'b1, 1);
        wait_req(1'b1, 20, n);
        check("pre_rst_wr_add", wr_sdram_add_o, 32'(2) << 9);
        rst_133 = 1'b0;
        #1;
        check("midrst_wr_req", wr_sdram_req_o, 0);
        check("midrst_rd_req", rd_sdram_req_o, 0);
        check("midrst_wr_add", wr_sdram_add_o, 0);
        check("midrst_rd_add", rd_sdram_add_o, 0);
        check("midrst_wr_done", wr_done_o, 0);
        check("midrst_rows", frame_rows_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
